// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   - rx_state_t : receive FSM state encoding
//   - PAR_*      : PARITY parameter mode constants
//   - OVS        : oversampling factor (s_ticks per bit)
//   - maj3       : 2-of-3 majority helper for the optional voted sampling
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int OVS = 16;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/baud_generator.sv
// -----------------------------------------------------------------------------
// baud_generator
// Free-running divisor counter producing a one-cycle s_tick every DVSR clocks.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   s_tick    : one-cycle pulse, 16x the baud rate
// -----------------------------------------------------------------------------
module baud_generator #(
    parameter int DVSR       = 326,
    parameter int DVSR_WIDTH = 9
) (
    input  logic clk,
    input  logic rst,
    output logic s_tick
);

    logic [DVSR_WIDTH-1:0] cnt;
    logic                  cnt_last;

    assign cnt_last = (cnt == DVSR_WIDTH'(DVSR - 1));
    assign s_tick   = cnt_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt_last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Show-ahead FIFO, W bits wide, 2^FIFO_W entries deep.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (clears storage too)
//   wr       : push w_data this cycle
//   w_data   : word to push
//   rd       : pop the head this cycle
//   r_data   : head word, read combinationally from storage
//   empty    : no entries (from registered pointers)
//   full     : all entries used (from registered pointers)
//   drop     : push rejected this cycle (full and no simultaneous pop)
// Handshake: a pop takes effect on any clock with rd=1 and empty=0; a push
// takes effect on any clock with wr=1 and (full=0 or rd=1). A push while full
// together with a pop is accepted, leaving occupancy unchanged.
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int W      = 10,
    parameter int FIFO_W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr,
    input  logic [W-1:0] w_data,
    input  logic         rd,
    output logic [W-1:0] r_data,
    output logic         empty,
    output logic         full,
    output logic         drop
);

    localparam int DEPTH = 1 << FIFO_W;

    logic [W-1:0]      mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [FIFO_W:0]   wptr;
    logic [FIFO_W:0]   rptr;
    logic [FIFO_W-1:0] widx;
    logic [FIFO_W-1:0] ridx;
    logic              wr_en;
    logic              rd_en;

    assign widx  = wptr[FIFO_W-1:0];
    assign ridx  = rptr[FIFO_W-1:0];
    assign empty = (wptr == rptr);
    assign full  = (wptr[FIFO_W] != rptr[FIFO_W]) && (widx == ridx);

    assign rd_en = rd & ~empty;
    assign wr_en = wr & (~full | rd);
    assign drop  = wr & full & ~rd;

    assign r_data = mem[ridx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[widx] <= w_data;
                wptr      <= wptr + 1'b1;
            end
            if (rd_en) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_ext.sv
// -----------------------------------------------------------------------------
// uart_rx_ext
// UART receiver with optional parity, configurable stop length and an RX FIFO
// carrying per-word framing/parity error flags.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   rx             : asynchronous serial input, idle high
//   rd             : pop the FIFO head
//   clr_ovr        : clear the sticky overrun flag
//   rd_data        : FIFO head data (DBIT bits)
//   rd_frame_err   : framing error stored with the head word
//   rd_parity_err  : parity error stored with the head word
//   rx_empty       : FIFO empty
//   rx_full        : FIFO full
//   overrun        : sticky, set when a received word is dropped
// Build option:
//   UART_RX_MAJORITY_EN : data/parity/stop bits are the 2-of-3 vote of the
//                         synchronised line at s=13, 14 and 15; otherwise the
//                         single value at s=15. Start validation is always a
//                         single sample at s=7.
// -----------------------------------------------------------------------------
module uart_rx_ext
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int PARITY     = 0,
    parameter int SB_TICK    = 16,
    parameter int DVSR       = 326,
    parameter int DVSR_WIDTH = 9,
    parameter int FIFO_W     = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    input  logic            rd,
    input  logic            clr_ovr,
    output logic [DBIT-1:0] rd_data,
    output logic            rd_frame_err,
    output logic            rd_parity_err,
    output logic            rx_empty,
    output logic            rx_full,
    output logic            overrun
);

    localparam int S_W = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int N_W = $clog2(DBIT);
    localparam int WW  = DBIT + 2;

    localparam logic [S_W-1:0] S_MID       = S_W'(7);
    localparam logic [S_W-1:0] S_LAST      = S_W'(OVS - 1);
    localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST      = N_W'(DBIT - 1);
    localparam logic           ODD_SENSE   = (PARITY == PAR_ODD) ? 1'b1 : 1'b0;

    // ---------------------------------------------------------------- sync
    logic rx_meta;
    logic rx_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // ---------------------------------------------------------------- tick
    logic s_tick;

    baud_generator #(
        .DVSR       (DVSR),
        .DVSR_WIDTH (DVSR_WIDTH)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .s_tick (s_tick)
    );

    // ---------------------------------------------------------------- FSM regs
    rx_state_t         state;
    logic [S_W-1:0]    s;
    logic [N_W-1:0]    n;
    logic [DBIT-1:0]   data;
    logic              parity_err;
    logic              frame_err;
    logic              push;
    logic [WW-1:0]     push_word;

    // ---------------------------------------------------------------- sampling
    logic bit_sample;

`ifdef UART_RX_MAJORITY_EN
    logic samp_a;
    logic samp_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else if (s_tick && (state == ST_DATA || state == ST_PARITY || state == ST_STOP)) begin
            if (s == S_W'(OVS - 3)) samp_a <= rx_sync;
            if (s == S_W'(OVS - 2)) samp_b <= rx_sync;
        end
    end

    assign bit_sample = maj3(samp_a, samp_b, rx_sync);
`else
    assign bit_sample = rx_sync;
`endif

    // Parity check result for the bit being sampled now.
    logic par_calc;
    assign par_calc = ((^data) ^ bit_sample) ^ ODD_SENSE;

    // For a 1-bit stop the frame check and the push land on the same tick,
    // so the pushed flag must include the sample taken on that tick.
    logic stop_fe;
    assign stop_fe = (s == S_LAST) ? ~bit_sample : frame_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            s          <= '0;
            n          <= '0;
            data       <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            push       <= 1'b0;
            push_word  <= '0;
        end else begin
            push <= 1'b0;
            if (s_tick) begin
                case (state)
                    ST_IDLE: begin
                        if (!rx_sync) begin
                            state <= ST_START;
                            s     <= '0;
                        end
                    end
                    ST_START: begin
                        if (s == S_MID) begin
                            if (!rx_sync) begin
                                state      <= ST_DATA;
                                s          <= '0;
                                n          <= '0;
                                parity_err <= 1'b0;
                                frame_err  <= 1'b0;
                            end else begin
                                // Line went high again before mid-start: glitch.
                                state <= ST_IDLE;
                                s     <= '0;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (s == S_LAST) begin
                            s    <= '0;
                            data <= {bit_sample, data[DBIT-1:1]};
                            if (n == N_LAST) begin
                                if (PARITY != PAR_NONE) state <= ST_PARITY;
                                else                    state <= ST_STOP;
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        if (s == S_LAST) begin
                            s          <= '0;
                            parity_err <= par_calc;
                            state      <= ST_STOP;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (s == S_LAST) begin
                            frame_err <= ~bit_sample;
                        end
                        if (s == S_STOP_LAST) begin
                            push      <= 1'b1;
                            push_word <= {stop_fe, parity_err, data};
                            state     <= ST_IDLE;
                            s         <= '0;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        s     <= '0;
                    end
                endcase
            end
        end
    end

    // ---------------------------------------------------------------- FIFO
    logic [WW-1:0] head;
    logic          drop;

    uart_rx_fifo #(
        .W      (WW),
        .FIFO_W (FIFO_W)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr     (push),
        .w_data (push_word),
        .rd     (rd),
        .r_data (head),
        .empty  (rx_empty),
        .full   (rx_full),
        .drop   (drop)
    );

    assign rd_data       = head[DBIT-1:0];
    assign rd_parity_err = head[DBIT];
    assign rd_frame_err  = head[DBIT+1];

    // Sticky overrun; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_ext.sv
module tb_uart_rx_ext;

    localparam int DVSR     = 4;
    localparam int BIT_CLKS = 16 * DVSR;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       rx0 = 1'b1, rd0 = 1'b0, clr0 = 1'b0;
    logic [7:0] d0;
    logic       fe0, pe0, em0, fu0, ov0;

    logic       rx1 = 1'b1, rd1 = 1'b0, clr1 = 1'b0;
    logic [7:0] d1;
    logic       fe1, pe1, em1, fu1, ov1;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];

    // ------------------------------------------------------------ clock/reset
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    uart_rx_ext #(.DBIT(8), .PARITY(0), .SB_TICK(16), .DVSR(DVSR), .DVSR_WIDTH(3), .FIFO_W(2)) dut0 (
        .clk(clk), .rst(rst), .rx(rx0), .rd(rd0), .clr_ovr(clr0),
        .rd_data(d0), .rd_frame_err(fe0), .rd_parity_err(pe0),
        .rx_empty(em0), .rx_full(fu0), .overrun(ov0)
    );

    uart_rx_ext #(.DBIT(8), .PARITY(1), .SB_TICK(16), .DVSR(DVSR), .DVSR_WIDTH(3), .FIFO_W(2)) dut1 (
        .clk(clk), .rst(rst), .rx(rx1), .rd(rd1), .clr_ovr(clr1),
        .rd_data(d1), .rd_frame_err(fe1), .rd_parity_err(pe1),
        .rx_empty(em1), .rx_full(fu1), .overrun(ov1)
    );

    // ------------------------------------------------------------ checker
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------ drivers
    task automatic wait_clks(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic drive_bit(input int sel, input logic v, input int clks);
        if (sel == 0) rx0 = v;
        else          rx1 = v;
        wait_clks(clks);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] data, input bit par_en,
                              input bit par_bit, input bit stop_val);
        drive_bit(sel, 1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive_bit(sel, data[i], BIT_CLKS);
        if (par_en) drive_bit(sel, par_bit, BIT_CLKS);
        drive_bit(sel, stop_val, BIT_CLKS);
        drive_bit(sel, 1'b1, BIT_CLKS);
    endtask

    task automatic pop0();
        rd0 = 1'b1;
        wait_clks(1);
        rd0 = 1'b0;
        wait_clks(1);
    endtask

    task automatic pop1();
        rd1 = 1'b1;
        wait_clks(1);
        rd1 = 1'b0;
        wait_clks(1);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        bit seen;
        wait_clks(4);

        // reset state, sampled while reset is held
        check("rst_empty", em0, 1);
        check("rst_full", fu0, 0);
        check("rst_ovr", ov0, 0);
        check("rst_data", d0, 0);
        check("rst_fe", fe0, 0);
        check("rst_pe", pe0, 0);
        rst = 1'b0;
        wait_clks(BIT_CLKS);

        // plain frame 0xA5
        send_frame(0, 8'hA5, 0, 0, 1);
        check("a5_empty", em0, 0);
        check("a5_data", d0, 8'hA5);
        check("a5_fe", fe0, 0);
        check("a5_pe", pe0, 0);
        pop0();
        check("a5_pop_empty", em0, 1);

        // stop bit low -> framing error
        send_frame(0, 8'h3C, 0, 0, 0);
        check("3c_data", d0, 8'h3C);
        check("3c_fe", fe0, 1);
        check("3c_pe", pe0, 0);
        pop0();
        check("3c_pop_empty", em0, 1);

        // 3-tick low pulse is a glitch
        drive_bit(0, 1'b0, 3 * DVSR);
        drive_bit(0, 1'b1, 3 * BIT_CLKS);
        check("glitch_empty", em0, 1);

        // pop on empty must not move pointers
        pop0();
        check("rd_empty_still_empty", em0, 1);
        send_frame(0, 8'h96, 0, 0, 1);
        check("after_rd_empty_data", d0, 8'h96);
        check("after_rd_empty_not_empty", em0, 0);
        pop0();
        check("after_rd_empty_empty", em0, 1);

        // five frames, no reads -> overrun, head is frame 1
        for (int i = 1; i <= 5; i++) begin
            logic [7:0] v;
            v = 8'(i * 8'h11);
            send_frame(0, v, 0, 0, 1);
            if (i <= 4) exp_q.push_back(v);
        end
        check("ovf_full", fu0, 1);
        check("ovf_ovr", ov0, 1);
        check("ovf_head", d0, 8'h11);
        clr0 = 1'b1;
        wait_clks(1);
        clr0 = 1'b0;
        wait_clks(1);
        check("clr_ovr", ov0, 0);
        while (exp_q.size() > 0) begin
            check("ovf_drain", d0, exp_q.pop_front());
            pop0();
        end
        check("ovf_drain_empty", em0, 1);

        // full FIFO, rd pulsed in the push cycle of frame 5
        for (int i = 1; i <= 4; i++) begin
            send_frame(0, 8'(8'h60 + i), 0, 0, 1);
            exp_q.push_back(8'(8'h60 + i));
        end
        check("pre5_full", fu0, 1);
        exp_q.push_back(8'h65);
        void'(exp_q.pop_front());
        seen = 0;
        fork
            send_frame(0, 8'h65, 0, 0, 1);
            begin
                for (int k = 0; k < 20 * BIT_CLKS && !seen; k++) begin
                    @(negedge clk);
                    if (dut0.push) seen = 1;
                end
                if (seen) begin
                    rd0 = 1'b1;
                    wait_clks(1);
                    rd0 = 1'b0;
                end
            end
        join
        check("push5_seen", seen, 1);
        check("push5_ovr", ov0, 0);
        check("push5_full", fu0, 1);
        while (exp_q.size() > 0) begin
            check("push5_drain", d0, exp_q.pop_front());
            pop0();
        end
        check("push5_empty", em0, 1);

        // reset mid-frame abandons it
        drive_bit(0, 1'b0, BIT_CLKS);
        drive_bit(0, 1'b1, BIT_CLKS / 2);
        rst = 1'b1;
        wait_clks(3);
        check("midrst_empty", em0, 1);
        rst = 1'b0;
        wait_clks(BIT_CLKS);
        check("midrst_still_empty", em0, 1);
        send_frame(0, 8'h5A, 0, 0, 1);
        check("midrst_data", d0, 8'h5A);
        check("midrst_fe", fe0, 0);

        // even parity on the second instance: 0x07 needs parity bit 1
        send_frame(1, 8'h07, 1, 0, 1);
        check("par0_data", d1, 8'h07);
        check("par0_pe", pe1, 1);
        pop1();
        send_frame(1, 8'h07, 1, 1, 1);
        check("par1_data", d1, 8'h07);
        check("par1_pe", pe1, 0);
        check("par1_fe", fe1, 0);
        pop1();
        check("par_empty", em1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
